fd_fetch_queue: RTL and testbench



---
 rtl/fd_fetch_queue.sv | 81 ++++++++
 tb/tb_fd_fetch_queue.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fd_fetch_queue.sv
// Fetch-to-decode instruction queue: in-order {PC, Instr} FIFO with valid/ready
// handshake on both sides. F_Ready is registered-state only, so decode stalls never reach fetch combinationally.
module fd_fetch_queue #(
  parameter int          DEPTH = 4,
  parameter int          PTR_W = 2,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             F_Valid,
  input  logic [31:0]      F_PC,
  input  logic [31:0]      F_Instr,
  output logic             F_Ready,
  output logic             D_Valid,
  output logic [31:0]      D_PC,
  output logic [31:0]      D_Instr,
  input  logic             D_Ready,
  input  logic             Flush,
  output logic [PTR_W:0]   Count
);

  localparam logic [PTR_W:0] FULL     = (PTR_W + 1)'(DEPTH);
  localparam logic [31:0]    RESET_PC = 32'h0000_3000;

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  assign F_Ready = (count_q != FULL);
  assign D_Valid = (count_q != '0);
  assign push    = F_Valid & F_Ready;
  assign pop     = D_Valid & D_Ready;

  assign D_PC    = D_Valid ? mem_q[rd_ptr_q][63:32] : RESET_PC;
  assign D_Instr = D_Valid ? mem_q[rd_ptr_q][31:0]  : NOP;
  assign Count   = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; contents are only observed when count says valid.
  always_ff @(posedge clk) begin
    if (push && !Flush) mem_q[wr_ptr_q] <= {F_PC, F_Instr};
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (!reset) count_q <= FULL);
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(count_q == '0 && pop));
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(count_q == FULL && push));

endmodule

// File: tb/tb_fd_fetch_queue.sv
// Directed plus randomized bench for fd_fetch_queue, checked against a queue-based
// model of an in-order buffer with a capacity of DEPTH entries.
module tb_fd_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        F_Valid = 1'b0;
  logic [31:0] F_PC = '0;
  logic [31:0] F_Instr = '0;
  logic        F_Ready;
  logic        D_Valid;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic        D_Ready = 1'b0;
  logic        Flush = 1'b0;
  logic [2:0]  Count;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] mq[$];

  fd_fetch_queue #(.DEPTH(4), .PTR_W(2), .NOP(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .F_Valid(F_Valid), .F_PC(F_PC), .F_Instr(F_Instr), .F_Ready(F_Ready),
    .D_Valid(D_Valid), .D_PC(D_PC), .D_Instr(D_Instr), .D_Ready(D_Ready),
    .Flush(Flush), .Count(Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output with what the model says the queue holds right now.
  task automatic check_model(input string tag);
    logic [63:0] head;
    head = (mq.size() != 0) ? mq[0] : {32'h0000_3000, 32'h0000_0000};
    chk({tag, "_count"},  64'(Count),   64'(mq.size()));
    chk({tag, "_dvalid"}, 64'(D_Valid), 64'(mq.size() != 0));
    chk({tag, "_fready"}, 64'(F_Ready), 64'(mq.size() < DEPTH));
    chk({tag, "_dpc"},    64'(D_PC),    64'(head[63:32]));
    chk({tag, "_dinstr"}, 64'(D_Instr), 64'(head[31:0]));
  endtask

  // Drive one cycle: check outputs before the edge, clock, then advance the model.
  task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                     input logic dr, input logic fl, input string tag);
    bit do_push, do_pop;
    F_Valid = fv; F_PC = pc; F_Instr = ins; D_Ready = dr; Flush = fl;
    #1;
    check_model(tag);
    do_push = fv && (mq.size() < DEPTH);
    do_pop  = dr && (mq.size() != 0);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({pc, ins});
    end
    #1;
  endtask

  initial begin
    #12;
    check_model("reset");
    @(negedge clk);
    reset = 1'b1;

    // Fill three entries with decode stalled.
    cyc(1, 32'h3000, 32'h3401_0001, 0, 0, "fill0");
    cyc(1, 32'h3004, 32'h3402_0002, 0, 0, "fill1");
    cyc(1, 32'h3008, 32'h0022_1821, 0, 0, "fill2");
    chk("three_count", 64'(Count), 64'd3);
    chk("three_dpc",   64'(D_PC), 64'h3000);
    chk("three_instr", 64'(D_Instr), 64'h3401_0001);
    chk("three_fready", 64'(F_Ready), 64'd1);

    cyc(1, 32'h300C, 32'h8C23_0004, 0, 0, "fill3");
    chk("full_fready", 64'(F_Ready), 64'd0);
    cyc(1, 32'h3010, 32'hDEAD_BEEF, 0, 0, "push_full");
    chk("full_count", 64'(Count), 64'd4);

    // Drain from full.
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(D_PC), 64'(32'h3000 + 4 * i));
      cyc(0, 32'h0, 32'h0, 1, 0, "drain");
    end
    chk("empty_dvalid", 64'(D_Valid), 64'd0);
    chk("empty_instr",  64'(D_Instr), 64'd0);
    chk("empty_count",  64'(Count), 64'd0);

    // Streaming: count settles at 1 and D_PC trails F_PC by one entry.
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        chk("stream_count", 64'(Count), 64'd1);
        chk("stream_dpc", 64'(D_PC), 64'(32'h3000 + 4 * (i - 1)));
      end
      cyc(1, 32'h3000 + 4 * i, 32'h1000_0000 + i, 1, 0, "stream");
    end

    // Build to three, then flush in a cycle that also pushes and pops.
    cyc(1, 32'h3028, 32'h2222_0001, 0, 0, "pre_flush0");
    cyc(1, 32'h302C, 32'h2222_0002, 0, 0, "pre_flush1");
    chk("preflush_count", 64'(Count), 64'd3);
    cyc(1, 32'h3030, 32'h2222_0003, 1, 1, "flush");
    chk("flush_count",  64'(Count), 64'd0);
    chk("flush_dvalid", 64'(D_Valid), 64'd0);
    chk("flush_fready", 64'(F_Ready), 64'd1);
    cyc(1, 32'h4000, 32'h3333_0000, 0, 0, "post_flush");
    chk("redirect_pc", 64'(D_PC), 64'h4000);

    // Asynchronous reset between edges with two entries held.
    cyc(1, 32'h4004, 32'h3333_0004, 0, 0, "pre_rst");
    chk("prerst_count", 64'(Count), 64'd2);
    F_Valid = 1'b0; D_Ready = 1'b0; Flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    mq.delete();
    chk("async_dvalid", 64'(D_Valid), 64'd0);
    chk("async_count",  64'(Count), 64'd0);
    check_model("async_rst");
    #2 reset = 1'b1;
    @(posedge clk); #1;
    cyc(1, 32'h3000, 32'h3401_0001, 0, 0, "after_rst");
    chk("after_rst_pc", 64'(D_PC), 64'h3000);

    // Randomized traffic including occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 32'h3000 + 4 * i, $urandom,
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), "rand");
    end
    check_model("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
